// File: rtl/apb_master_arb_ctrl.sv
// APB master controller: round-robin arbitration over NUM_REQ requesters, address
// decode to one-hot PSELx, IDLE/SETUP/ACCESS sequencing with wait-state timeout.
module apb_master_arb_ctrl #(
    parameter int NUM_REQ       = 4,
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int NO_OF_SLAVES  = 16,
    parameter int SLV_SEL_LSB   = 28,
    parameter int TIMEOUT       = 16
) (
    input  logic                              pclk,
    input  logic                              preset_n,
    input  logic [NUM_REQ-1:0]                req_valid,
    output logic [NUM_REQ-1:0]                req_ready,
    input  logic [NUM_REQ*ADDRESS_WIDTH-1:0]  req_addr,
    input  logic [NUM_REQ-1:0]                req_write,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]     req_wdata,
    input  logic [NUM_REQ*(DATA_WIDTH/8)-1:0] req_strb,
    input  logic [NUM_REQ*3-1:0]              req_prot,
    output logic                              rsp_valid,
    output logic [2:0]                        rsp_id,
    output logic [DATA_WIDTH-1:0]             rsp_rdata,
    output logic                              rsp_slverr,
    output logic                              rsp_decerr,
    output logic                              rsp_timeout,
    output logic [NO_OF_SLAVES-1:0]           pselx,
    output logic                              penable,
    output logic                              pwrite,
    output logic [ADDRESS_WIDTH-1:0]          paddr,
    output logic [DATA_WIDTH-1:0]             pwdata,
    output logic [DATA_WIDTH/8-1:0]           pstrb,
    output logic [2:0]                        pprot,
    input  logic [DATA_WIDTH-1:0]             prdata,
    input  logic                              pready,
    input  logic                              pslverr,
    output logic [1:0]                        state
);
    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int CNT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {
        IDLE_S   = 2'b00,
        SETUP_S  = 2'b01,
        ACCESS_S = 2'b10,
        DECERR_S = 2'b11
    } op_state_e;

    op_state_e                 st_q, st_d;
    logic [2:0]                last_q, last_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [NO_OF_SLAVES-1:0]   pselx_q, pselx_d;
    logic                      penable_q, penable_d;
    logic                      pwrite_q, pwrite_d;
    logic [ADDRESS_WIDTH-1:0]  paddr_q, paddr_d;
    logic [DATA_WIDTH-1:0]     pwdata_q, pwdata_d;
    logic [STRB_W-1:0]         pstrb_q, pstrb_d;
    logic [2:0]                pprot_q, pprot_d;
    logic                      rsp_valid_q, rsp_valid_d;
    logic [2:0]                rsp_id_q, rsp_id_d;
    logic [DATA_WIDTH-1:0]     rsp_rdata_q, rsp_rdata_d;
    logic                      rsp_slverr_q, rsp_slverr_d;
    logic                      rsp_decerr_q, rsp_decerr_d;
    logic                      rsp_timeout_q, rsp_timeout_d;

    logic [7:0]                req_valid_pad;
    logic [3:0]                rr_idx;
    logic                      grant_vld;
    logic [2:0]                grant_idx;
    logic [ADDRESS_WIDTH-1:0]  g_addr;
    logic                      g_write;
    logic [DATA_WIDTH-1:0]     g_wdata;
    logic [STRB_W-1:0]         g_strb;
    logic [2:0]                g_prot;
    logic [3:0]                g_slv;
    logic                      dec_ok;
    logic                      tmo_fire, done, arb_en;

    assign req_valid_pad = 8'(req_valid);

    always_comb begin
        tmo_fire = (TIMEOUT > 0) && (st_q == ACCESS_S) && !pready
                   && (cnt_q == CNT_W'(TIMEOUT - 1));
        done     = (st_q == ACCESS_S) && (pready || tmo_fire);
        arb_en   = (st_q == IDLE_S) || done;
    end

    // Search starts one past the last grant so the previous winner is lowest priority
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        rr_idx    = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            rr_idx = {1'b0, last_q} + 4'(k);
            if (rr_idx >= 4'(NUM_REQ))
                rr_idx = rr_idx - 4'(NUM_REQ);
            if (arb_en && !grant_vld && req_valid_pad[rr_idx[2:0]]) begin
                grant_vld = 1'b1;
                grant_idx = rr_idx[2:0];
            end
        end
    end

    always_comb begin
        req_ready = '0;
        g_addr    = '0;
        g_write   = 1'b0;
        g_wdata   = '0;
        g_strb    = '0;
        g_prot    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_idx == 3'(i)) begin
                g_addr       = req_addr[i*ADDRESS_WIDTH +: ADDRESS_WIDTH];
                g_write      = req_write[i];
                g_wdata      = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
                g_strb       = req_strb[i*STRB_W +: STRB_W];
                g_prot       = req_prot[i*3 +: 3];
                req_ready[i] = grant_vld;
            end
        end
        g_slv  = g_addr[SLV_SEL_LSB +: 4];
        dec_ok = int'(g_slv) < NO_OF_SLAVES;
    end

    always_comb begin
        st_d          = st_q;
        last_d        = last_q;
        cnt_d         = cnt_q;
        pselx_d       = pselx_q;
        penable_d     = penable_q;
        pwrite_d      = pwrite_q;
        paddr_d       = paddr_q;
        pwdata_d      = pwdata_q;
        pstrb_d       = pstrb_q;
        pprot_d       = pprot_q;
        rsp_valid_d   = 1'b0;
        rsp_id_d      = '0;
        rsp_rdata_d   = '0;
        rsp_slverr_d  = 1'b0;
        rsp_decerr_d  = 1'b0;
        rsp_timeout_d = 1'b0;
        case (st_q)
            SETUP_S: begin
                penable_d = 1'b1;
                cnt_d     = '0;
                st_d      = ACCESS_S;
            end
            ACCESS_S: begin
                if (done) begin
                    rsp_valid_d = 1'b1;
                    rsp_id_d    = last_q;
                    if (tmo_fire) begin
                        rsp_slverr_d  = 1'b1;
                        rsp_timeout_d = 1'b1;
                    end else begin
                        rsp_slverr_d = pslverr;
                        rsp_rdata_d  = (!pwrite_q && !pslverr) ? prdata : '0;
                    end
                    pselx_d   = '0;
                    penable_d = 1'b0;
                    st_d      = IDLE_S;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DECERR_S: begin
                rsp_valid_d  = 1'b1;
                rsp_id_d     = last_q;
                rsp_slverr_d = 1'b1;
                rsp_decerr_d = 1'b1;
                st_d         = IDLE_S;
            end
            default: ;
        endcase
        // A grant overrides the completion path, giving back-to-back SETUP
        if (grant_vld) begin
            last_d    = grant_idx;
            penable_d = 1'b0;
            if (dec_ok) begin
                st_d     = SETUP_S;
                pselx_d  = NO_OF_SLAVES'(1) << g_slv;
                paddr_d  = g_addr;
                pwrite_d = g_write;
                pwdata_d = g_write ? g_wdata : '0;
                pstrb_d  = g_write ? g_strb : '0;
                pprot_d  = g_prot;
            end else begin
                st_d    = DECERR_S;
                pselx_d = '0;
            end
        end
    end

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            st_q          <= IDLE_S;
            last_q        <= 3'(NUM_REQ - 1);
            cnt_q         <= '0;
            pselx_q       <= '0;
            penable_q     <= 1'b0;
            pwrite_q      <= 1'b0;
            paddr_q       <= '0;
            pwdata_q      <= '0;
            pstrb_q       <= '0;
            pprot_q       <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_id_q      <= '0;
            rsp_rdata_q   <= '0;
            rsp_slverr_q  <= 1'b0;
            rsp_decerr_q  <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            st_q          <= st_d;
            last_q        <= last_d;
            cnt_q         <= cnt_d;
            pselx_q       <= pselx_d;
            penable_q     <= penable_d;
            pwrite_q      <= pwrite_d;
            paddr_q       <= paddr_d;
            pwdata_q      <= pwdata_d;
            pstrb_q       <= pstrb_d;
            pprot_q       <= pprot_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_id_q      <= rsp_id_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_slverr_q  <= rsp_slverr_d;
            rsp_decerr_q  <= rsp_decerr_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    assign pselx       = pselx_q;
    assign penable     = penable_q;
    assign pwrite      = pwrite_q;
    assign paddr       = paddr_q;
    assign pwdata      = pwdata_q;
    assign pstrb       = pstrb_q;
    assign pprot       = pprot_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_id      = rsp_id_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_slverr  = rsp_slverr_q;
    assign rsp_decerr  = rsp_decerr_q;
    assign rsp_timeout = rsp_timeout_q;
    // The decode-error hold cycle is invisible on the state port
    assign state       = (st_q == DECERR_S) ? 2'b00 : st_q;

endmodule
